stream_in_tx: RTL and testbench
===============================

# stream_in_tx

Transmit side of the stream-in start/ready four-phase handshake. Buffers upstream data words in a small FIFO, requests a burst by raising `start_stream_in`, waits for the loop-control FSM to answer with `ready_stream_in`, and then streams exactly `burst_len` words to the compute datapath. It sits between the host/network ingress and the loop-sequencing FSM that consumes the stream.

## Interface
Parameters:
- `DATA_W`, 32, stream word width
- `DEPTH`, 16, FIFO depth in words (power of two, ≥2)
- `LEN_W`, 16, burst length counter width
- `TIMEOUT`, 1024, handshake watchdog limit in cycles (used only with `STREAM_IN_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `s_tdata`  in  DATA_W  upstream word
- `s_tvalid`  in  1  upstream word valid
- `s_tready`  out  1  FIFO can accept
- `go`  in  1  single-cycle request to send one burst
- `burst_len`  in  LEN_W  words in burst, sampled with `go`
- `start_stream_in`  out  1  handshake request to consumer FSM
- `ready_stream_in`  in  1  handshake acknowledge from consumer FSM
- `m_data`  out  DATA_W  stream word to datapath
- `m_valid`  out  1  `m_data` valid
- `busy`  out  1  state ≠ IDLE
- `burst_done`  out  1  one-cycle pulse after last word
- `timeout_err`  out  1  sticky handshake timeout flag

## Operation
- States: IDLE, REQ, HOLD, SEND.
- IDLE: `go`=1, `burst_len`≠0 and `ready_stream_in`=0 → latch `burst_len` into `remaining`, go REQ. `go` with `burst_len`=0, or while `ready_stream_in`=1 (previous handshake not returned to zero), is ignored. `go` outside IDLE is ignored.
- REQ: `start_stream_in`=1. On sampled `ready_stream_in`=1 → HOLD.
- HOLD: `start_stream_in`=0 (one cycle, lets consumer see start low and leave its hold state) → SEND unconditionally.
- SEND: each cycle FIFO non-empty → pop, `m_valid`=1, `remaining`−1. FIFO empty → `m_valid`=0, wait (no downstream backpressure exists). Pop of final word (`remaining`=1) → IDLE, `burst_done`=1 next cycle.
- FIFO: push when `s_tvalid`&`s_tready`; `s_tready`=!full. Simultaneous push/pop allowed when not full; when full only pop occurs that cycle. Pointers wrap modulo DEPTH; occupancy count width clog2(DEPTH)+1.
- Upstream may fill FIFO in any state, including before `go`.

## Timing
- Reset values: `start_stream_in`=0, `m_valid`=0, `m_data`=0, `s_tready`=1, `busy`=0, `burst_done`=0, `timeout_err`=0; FIFO empty, state IDLE.
- All outputs registered except `s_tready` (decoded from registered full flag).
- `go` at cycle t → `start_stream_in`=1 at t+1.
- `ready_stream_in` sampled 1 at cycle r → `start_stream_in`=0 at r+1, first `m_valid` no earlier than r+2.
- Minimum burst: N words with FIFO pre-filled → `m_valid` high r+2..r+N+1, `burst_done` at r+N+2.
- Reset mid-burst: immediate return to IDLE, FIFO flushed, all outputs to reset values.

## Configuration
- `STREAM_IN_TIMEOUT_EN` defined: cycle counter runs in REQ; reaching `TIMEOUT` without `ready_stream_in` → drop `start_stream_in`, set `timeout_err` (sticky until `rst`), return IDLE; FIFO contents retained.
- Not defined: REQ waits indefinitely; counter absent; `timeout_err` tied 0.

## Structure
- Shared package: state enum (IDLE/REQ/HOLD/SEND), default widths, `TIMEOUT` default.
- One sub-module: `stream_in_fifo` (synchronous FIFO, async-reset pointers, full/empty/count).

## Test plan
- Pre-fill 4 words (0xA0..0xA3), `go` with `burst_len`=4, consumer raises ready 3 cycles after start → start high 3 cycles then low, `m_data` 0xA0..0xA3 on four consecutive cycles from r+2, `burst_done` one cycle after.
- `burst_len`=6, FIFO holds 2, remaining 4 arrive 5 cycles later → `m_valid` gaps while empty, exactly 6 words total, then IDLE.
- Push 17 words into DEPTH=16 with no burst → `s_tready`=0 after 16th, 17th held; burst of 16 drains in order, pointer wrap verified with second burst.
- `go` while `ready_stream_in`=1, and `go` with `burst_len`=0 → no `start_stream_in`, `busy` stays 0.
- Assert `rst` in SEND after 2 of 5 words → outputs at reset values same cycle, FIFO empty, next `go` handshake restarts cleanly.
- With `STREAM_IN_TIMEOUT_EN`, TIMEOUT=8, ready never asserted → start drops after 8 cycles, `timeout_err`=1 sticky, FIFO occupancy unchanged.

Source files
------------

// File: rtl/stream_in_tx_pkg.sv
// Shared defaults and FSM state encoding for the stream-in transmitter
// (stream_in_tx) and its FIFO.
package stream_in_tx_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int DEPTH_DEF   = 16;
  localparam int LEN_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 1024;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_HOLD = 2'd2;
  localparam state_t ST_SEND = 2'd3;

endpackage

// File: rtl/stream_in_fifo.sv
// Synchronous FIFO for stream_in_tx: async-reset pointers and occupancy,
// registered full/empty flags, combinational read of the head word.
module stream_in_fifo
  import stream_in_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_in_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_next;
  logic              push;
  logic              pop;

  // A full FIFO refuses the write, so only the pop takes effect that cycle.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + (AW + 1)'(1);
    end else if (pop && !push) begin
      count_next = count - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
      full  <= (count_next == (AW + 1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/stream_in_tx.sv
// Stream-in transmitter: buffers upstream words, runs the start/ready
// handshake, then streams burst_len words. Optional watchdog: STREAM_IN_TIMEOUT_EN.
module stream_in_tx
  import stream_in_tx_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              go,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              start_stream_in,
  input  logic              ready_stream_in,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              busy,
  output logic              burst_done,
  output logic              timeout_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("stream_in_tx: TIMEOUT must be at least 1");
  end

  state_t            state;
  state_t            state_next;
  logic [LEN_W-1:0]  remaining;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              last_pop;
  logic              timeout_hit;
  logic              done_pend;

  assign s_tready = !fifo_full;

  stream_in_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s_tvalid),
    .wr_data (s_tdata),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Words are already popped during HOLD so the registered m_valid shows the
  // first word two cycles after ready is sampled.
  assign pop      = (state == ST_HOLD || state == ST_SEND) && !fifo_empty;
  assign last_pop = pop && (remaining == LEN_W'(1));

`ifdef STREAM_IN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT) + 1;

  logic [TO_W-1:0] wait_cnt;
  logic            err_q;

  assign timeout_hit = (state == ST_REQ) && !ready_stream_in &&
                       (wait_cnt == TO_W'(TIMEOUT - 1));
  assign timeout_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ST_REQ && !ready_stream_in) begin
        wait_cnt <= wait_cnt + TO_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (go && burst_len != '0 && !ready_stream_in) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ready_stream_in) begin
          state_next = ST_HOLD;
        end else if (timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_HOLD: begin
        state_next = last_pop ? ST_IDLE : ST_SEND;
      end
      ST_SEND: begin
        if (last_pop) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      remaining       <= '0;
      start_stream_in <= 1'b0;
      m_valid         <= 1'b0;
      m_data          <= '0;
      busy            <= 1'b0;
      done_pend       <= 1'b0;
      burst_done      <= 1'b0;
    end else begin
      state           <= state_next;
      busy            <= (state_next != ST_IDLE);
      start_stream_in <= (state_next == ST_REQ);
      m_valid         <= pop;
      if (pop) begin
        m_data <= fifo_rd_data;
      end
      // burst_done trails the final word's m_valid by one cycle.
      done_pend  <= last_pop;
      burst_done <= done_pend;
      if (state == ST_IDLE && state_next == ST_REQ) begin
        remaining <= burst_len;
      end else if (pop) begin
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_in_tx.sv
// Scoreboard bench for stream_in_tx: stimulus queues expected words, a
// negedge monitor compares every m_valid word; timing checks are directed.
module tb_stream_in_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        go;
  logic [15:0] burst_len;
  logic        start_stream_in;
  logic        ready_stream_in;
  logic [31:0] m_data;
  logic        m_valid;
  logic        busy;
  logic        burst_done;
  logic        timeout_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] exp_q[$];

  stream_in_tx #(
    .DATA_W  (32),
    .DEPTH   (16),
    .LEN_W   (16),
    .TIMEOUT (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_tdata         (s_tdata),
    .s_tvalid        (s_tvalid),
    .s_tready        (s_tready),
    .go              (go),
    .burst_len       (burst_len),
    .start_stream_in (start_stream_in),
    .ready_stream_in (ready_stream_in),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .busy            (busy),
    .burst_done      (burst_done),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && m_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h, expected no word", m_data);
      end else begin
        check("m_data", m_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    s_tdata  = d;
    s_tvalid = 1'b1;
    exp_q.push_back(d);
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic do_burst(input int n, input int rdy_delay, input bit prefilled);
    int r_edge;
    int first_v;
    int done_edge;
    int nvalid;
    go        = 1'b1;
    burst_len = 16'(n);
    tick();
    go = 1'b0;
    check("start_rise", 32'(start_stream_in), 32'd1);
    check("busy_high", 32'(busy), 32'd1);
    for (int k = 1; k < rdy_delay; k++) begin
      tick();
      check("start_held", 32'(start_stream_in), 32'd1);
    end
    ready_stream_in = 1'b1;
    tick();
    r_edge = cyc;
    check("start_fall", 32'(start_stream_in), 32'd0);
    ready_stream_in = 1'b0;
    first_v   = -1;
    done_edge = -1;
    nvalid    = 0;
    for (int k = 0; k < 300 && done_edge < 0; k++) begin
      tick();
      if (m_valid) begin
        nvalid++;
        if (first_v < 0) first_v = cyc;
      end
      if (burst_done) done_edge = cyc;
    end
    check("burst_done_seen", 32'(done_edge >= 0), 32'd1);
    check("word_count", 32'(nvalid), 32'(n));
    check("busy_idle", 32'(busy), 32'd0);
    if (prefilled) begin
      check("first_valid_lat", 32'(first_v - r_edge), 32'd1);
      check("done_lat", 32'(done_edge - r_edge), 32'(n + 1));
    end else begin
      check("gap_present", 32'(done_edge - first_v > n), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy;
    int seen;
    rst             = 1'b1;
    s_tdata         = '0;
    s_tvalid        = 1'b0;
    go              = 1'b0;
    burst_len       = '0;
    ready_stream_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_start", 32'(start_stream_in), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_burst_done", 32'(burst_done), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    tick();

    // Pre-filled 4-word burst, ready raised 3 cycles after start.
    for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
    do_burst(4, 3, 1'b1);

    // 6-word burst with only 2 buffered; the rest arrive later.
    push_word(32'hB0);
    push_word(32'hB1);
    fork
      do_burst(6, 2, 1'b0);
      begin
        repeat (5) tick();
        for (int i = 2; i < 6; i++) push_word(32'hB0 + 32'(i));
      end
    join

    // Fill to DEPTH, hold a 17th word, drain 16, then a wrapped burst.
    for (int i = 0; i < 16; i++) push_word(32'h100 + 32'(i));
    check("full_tready", 32'(s_tready), 32'd0);
    s_tdata  = 32'h110;
    s_tvalid = 1'b1;
    exp_q.push_back(32'h110);
    repeat (3) tick();
    check("full_held", 32'(s_tready), 32'd0);
    fork
      do_burst(16, 1, 1'b1);
      begin
        rdy = 0;
        for (int k = 0; k < 100 && rdy == 0; k++) begin
          rdy = int'(s_tready);
          tick();
        end
        s_tvalid = 1'b0;
        check("word17_accepted", 32'(rdy), 32'd1);
      end
    join
    for (int i = 1; i < 4; i++) push_word(32'h110 + 32'(i));
    do_burst(4, 2, 1'b1);

    // Ignored go requests.
    ready_stream_in = 1'b1;
    go              = 1'b1;
    burst_len       = 16'd3;
    tick();
    go              = 1'b0;
    ready_stream_in = 1'b0;
    tick();
    check("go_ready_start", 32'(start_stream_in), 32'd0);
    check("go_ready_busy", 32'(busy), 32'd0);
    go        = 1'b1;
    burst_len = 16'd0;
    tick();
    go = 1'b0;
    tick();
    check("go_zero_start", 32'(start_stream_in), 32'd0);
    check("go_zero_busy", 32'(busy), 32'd0);

    // Reset after 2 of 5 words.
    for (int i = 0; i < 5; i++) push_word(32'h50 + 32'(i));
    go        = 1'b1;
    burst_len = 16'd5;
    tick();
    go              = 1'b0;
    ready_stream_in = 1'b1;
    tick();
    ready_stream_in = 1'b0;
    seen = 0;
    for (int k = 0; k < 50 && seen < 2; k++) begin
      tick();
      if (m_valid) seen++;
    end
    check("abort_words_seen", 32'(seen), 32'd2);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_start", 32'(start_stream_in), 32'd0);
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_m_data", m_data, 32'd0);
    check("mid_rst_s_tready", 32'(s_tready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_burst_done", 32'(burst_done), 32'd0);
    exp_q.delete();
    #2;
    rst = 1'b0;
    tick();
    push_word(32'h60);
    push_word(32'h61);
    do_burst(2, 1, 1'b1);

`ifdef STREAM_IN_TIMEOUT_EN
    // Watchdog: ready never returned.
    for (int i = 0; i < 3; i++) push_word(32'h70 + 32'(i));
    go        = 1'b1;
    burst_len = 16'd3;
    tick();
    go = 1'b0;
    check("to_start_rise", 32'(start_stream_in), 32'd1);
    for (int k = 1; k < 8; k++) tick();
    check("to_start_last", 32'(start_stream_in), 32'd1);
    tick();
    check("to_start_drop", 32'(start_stream_in), 32'd0);
    check("to_err_set", 32'(timeout_err), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("to_err_sticky", 32'(timeout_err), 32'd1);
    do_burst(3, 1, 1'b1);
    check("to_err_after_burst", 32'(timeout_err), 32'd1);
`else
    check("no_timeout_err", 32'(timeout_err), 32'd0);
`endif

    repeat (3) tick();
    check("leftover_words", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
